// File: rtl/disp_pkg.sv
// Shared constants, state encoding and request-priority helpers for the
// seven-segment scan controller.
package disp_pkg;
   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] SEG_DASH   = 7'b0111111;
   localparam logic [6:0] SEG_BLANK  = 7'b1111111;
   localparam logic [3:0] AN_OFF     = 4'b1111;

   typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_e;

   function automatic logic [1:0] top_req(input logic [2:0] r);
      if (r[2])      return 2'd2;
      else if (r[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   // Any request strictly above the given owner index.
   function automatic logic higher_req(input logic [2:0] r, input logic [1:0] o);
      case (o)
         2'd0:    return |r[2:1];
         2'd1:    return r[2];
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Request/digit-data inputs and display pin outputs of the scan controller.
interface disp_scan_ctrl_if;
   logic [2:0]  req;
   logic [27:0] digits0;
   logic [27:0] digits1;
   logic [27:0] digits2;
   logic [2:0]  gnt;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   modport master (output req, digits0, digits1, digits2,
                   input  gnt, seg, an, frame_done);
   modport slave  (input  req, digits0, digits1, digits2,
                   output gnt, seg, an, frame_done);
endinterface

// File: rtl/disp_prescaler.sv
// Free-running slot prescaler: tick is high on the last cycle of each slot.
module disp_prescaler #(
   parameter int PRESCALE = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] r_cnt;

   assign tick = (r_cnt == CW'(PRESCALE - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_cnt <= '0;
      else if (tick) r_cnt <= '0;
      else           r_cnt <= r_cnt + CW'(1);
   end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit scan controller with fixed-priority, minimum-hold display
// arbitration and a blank frame on every ownership change.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int PRESCALE = 100000,
   parameter int MIN_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   disp_scan_ctrl_if.slave  io_disp
);
   localparam int HW = $clog2(MIN_HOLD + 1);

   logic          w_tick, w_bnd;
   logic [1:0]    r_idx, w_idx_nxt;
   state_e        r_state, w_state_nxt;
   logic [1:0]    r_owner, w_owner_nxt;
   logic [HW-1:0] r_hold, w_hold_nxt;
   logic [2:0]    r_gnt, w_gnt_nxt;
   logic [3:0]    r_an, w_an_nxt;
   logic [6:0]    r_seg, w_seg_nxt;
   logic          r_fd;
   logic [27:0]   w_dig;

   disp_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   assign w_bnd     = w_tick && (r_idx == 2'(NUM_DIGITS - 1));
   assign w_idx_nxt = r_idx + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_state <= IDLE;
         r_owner <= '0;
         r_hold  <= '0;
      end else begin
         if (w_tick) r_idx <= w_idx_nxt;
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // r_hold counts frames already completed before this boundary, so the
   // frame closing now brings the total to r_hold+1.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_hold_nxt  = r_hold;
      if (w_bnd) begin
         case (r_state)
            OWN: begin
               if (!io_disp.req[r_owner] ||
                   (higher_req(io_disp.req, r_owner) && r_hold >= HW'(MIN_HOLD - 1)))
                  w_state_nxt = SWITCH;
               if (r_hold != HW'(MIN_HOLD)) w_hold_nxt = r_hold + HW'(1);
            end
            default: begin
               if (|io_disp.req) begin
                  w_state_nxt = OWN;
                  w_owner_nxt = top_req(io_disp.req);
                  w_hold_nxt  = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      case (w_owner_nxt)
         2'd2:    w_dig = io_disp.digits2;
         2'd1:    w_dig = io_disp.digits1;
         default: w_dig = io_disp.digits0;
      endcase
      w_gnt_nxt = '0;
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = SEG_DASH;
      case (w_state_nxt)
         OWN: begin
            w_gnt_nxt = 3'b001 << w_owner_nxt;
            w_seg_nxt = w_dig[7*int'(w_idx_nxt) +: 7];
         end
         SWITCH: begin
            w_an_nxt  = AN_OFF;
            w_seg_nxt = SEG_BLANK;
         end
         default: ;
      endcase
   end

   // Pins move only on the edge that opens a slot; digit data is sampled there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt <= '0;
         r_an  <= AN_OFF;
         r_seg <= SEG_BLANK;
         r_fd  <= 1'b0;
      end else begin
         r_fd <= w_bnd;
         if (w_tick) begin
            r_gnt <= w_gnt_nxt;
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
         end
      end
   end

   assign io_disp.gnt        = r_gnt;
   assign io_disp.an         = r_an;
   assign io_disp.seg        = r_seg;
   assign io_disp.frame_done = r_fd;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench: a slot/frame-level reference model predicts the pins for
// every clock and a monitor compares them on the falling edge.
module tb_disp_scan_ctrl;
   localparam int P  = 4;
   localparam int MH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   disp_scan_ctrl_if bus ();

   disp_scan_ctrl #(.PRESCALE(P), .MIN_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .io_disp (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] gnt;
      logic [3:0] an;
      logic [6:0] seg;
      logic       fd;
   } obs_t;

   obs_t expq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: edges since reset release, mode 0=idle 1=owned 2=blank frame.
   int   m_edges, m_mode, m_owner, m_frames;
   obs_t m_out;

   task automatic m_reset();
      m_edges  = 0;
      m_mode   = 0;
      m_owner  = 0;
      m_frames = 0;
      m_out    = '{gnt: 3'b000, an: 4'b1111, seg: 7'b1111111, fd: 1'b0};
   endtask

   function automatic int top_of(input logic [2:0] r);
      return r[2] ? 2 : (r[1] ? 1 : 0);
   endfunction

   task automatic m_step(input logic [2:0] rq, input logic [83:0] dg);
      int s, d;
      m_edges++;
      m_out.fd = 1'b0;
      if (m_edges % P == 0) begin
         s = m_edges / P;
         d = s % 4;
         if (d == 0) begin
            m_out.fd = 1'b1;
            if (m_mode == 1) begin
               m_frames++;
               if (!rq[m_owner] || (((rq >> (m_owner + 1)) != 0) && m_frames >= MH))
                  m_mode = 2;
            end else if (rq != 3'b000) begin
               m_mode   = 1;
               m_owner  = top_of(rq);
               m_frames = 0;
            end else begin
               m_mode = 0;
            end
         end
         case (m_mode)
            0: begin
               m_out.gnt = 3'b000;
               m_out.an  = ~(4'b0001 << d);
               m_out.seg = 7'b0111111;
            end
            1: begin
               m_out.gnt = 3'b001 << m_owner;
               m_out.an  = ~(4'b0001 << d);
               m_out.seg = dg[m_owner*28 + d*7 +: 7];
            end
            default: begin
               m_out.gnt = 3'b000;
               m_out.an  = 4'b1111;
               m_out.seg = 7'b1111111;
            end
         endcase
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         if (rst) m_reset();
         else     m_step(bus.req, {bus.digits2, bus.digits1, bus.digits0});
         expq.push_back(m_out);
      end
   end

   initial begin
      forever begin
         @(posedge rst);
         m_reset();
         expq.delete();
      end
   end

   initial begin
      obs_t e, g;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            g = {bus.gnt, bus.an, bus.seg, bus.frame_done};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL cyc t=%0t got gnt=%b an=%b seg=%b fd=%b, want gnt=%b an=%b seg=%b fd=%b",
                        $time, g.gnt, g.an, g.seg, g.fd, e.gnt, e.an, e.seg, e.fd);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_pins(input string name);
      n_tests++;
      if ({bus.gnt, bus.an, bus.seg, bus.frame_done} !== {3'b000, 4'b1111, 7'b1111111, 1'b0}) begin
         n_fail++;
         $display("FAIL %s got gnt=%b an=%b seg=%b fd=%b, want 000/1111/1111111/0",
                  name, bus.gnt, bus.an, bus.seg, bus.frame_done);
      end
   endtask

   task automatic rnd_digits();
      bus.digits0 = 28'($urandom());
      bus.digits1 = 28'($urandom());
      bus.digits2 = 28'($urandom());
   endtask

   initial begin
      bus.req = 3'b000;
      rnd_digits();
      bus.digits0 = 28'h0ABCDEF;
      cyc(3);
      check_reset_pins("rst_hold");
      rst = 1'b0;
      cyc(40);
      // First grant raised mid-frame, then preemption against the hold rule.
      cyc(6);
      bus.req = 3'b001;
      cyc(30);
      bus.req = 3'b101;
      cyc(16 * 4);
      // Lower-priority request alongside owner 2 for ten frames.
      cyc(16 * 10);
      bus.req = 3'b010;
      cyc(48);
      bus.req = 3'b000;
      cyc(48);
      bus.req = 3'b001;
      cyc(24);
      bus.req = 3'b010;
      cyc(48);
      repeat (40) begin
         cyc($urandom_range(1, 24));
         if ($urandom_range(0, 2) == 0) rnd_digits();
         bus.req = 3'($urandom_range(0, 7));
      end
      // Asynchronous reset in the middle of a blank frame.
      bus.req = 3'b001;
      cyc(40);
      bus.req = 3'b000;
      for (int k = 0; k < 64 && m_mode != 2; k++) cyc(1);
      n_tests++;
      if (m_mode != 2) begin
         n_fail++;
         $display("FAIL switch_wait got mode=%0d, want 2 within 64 cycles", m_mode);
      end
      cyc(5);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_pins("rst_async");
      #1 rst = 1'b0;
      cyc(48);
      cyc(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
